// File: rtl/mem_ctrl_responder.sv
// Word-addressed SRAM responder: clears storage after reset, then serves byte-masked
// writes and reads through a fixed-latency pipeline into an in-order response FIFO.
module mem_ctrl_responder #(
    parameter int DEPTH_WORDS     = 256,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_WIDTH        = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic [31:0]         req_addr_i,
    input  logic [31:0]         req_wdata_i,
    input  logic [3:0]          req_strb_i,
    input  logic [ID_WIDTH-1:0] req_id_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_rdata_o,
    output logic [ID_WIDTH-1:0] rsp_id_o,
    output logic                rsp_error_o,
    output logic                init_done_o,
    output logic [15:0]         err_count_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic                err;
        logic [ID_WIDTH-1:0] id;
        logic [31:0]         rdata;
    } rsp_t;

    state_t        state_q, state_d;
    logic [AW:0]   init_idx_q;
    logic          init_last;
    logic          clear_en;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [29:0]   word_addr;
    logic [AW-1:0] word_idx;
    logic          addr_err;
    logic          accept;
    logic          pop;
    logic          push;
    logic          wr_en;
    rsp_t          new_rsp;

    logic [LATENCY-1:0] pipe_valid_q;
    rsp_t               pipe_q [LATENCY];

    rsp_t          fifo_q [MAX_OUTSTANDING];
    rsp_t          head;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] fifo_cnt_q;
    logic [CW-1:0] outst_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // init_idx_q counts 0..DEPTH_WORDS, so its MSB marks "every word cleared"
    assign init_last = init_idx_q[AW];
    assign clear_en  = (state_q == ST_INIT) && !init_last;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        unique case (state_q)
            ST_INIT: if (init_last) state_d = ST_RUN;
            ST_RUN:  req_ready_o = !rst_i && (outst_q < CW'(MAX_OUTSTANDING));
        endcase
    end

    assign init_done_o = (state_q == ST_RUN);

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (clear_en) init_idx_q <= init_idx_q + (AW + 1)'(1);
        end
    end

    assign word_addr = req_addr_i[31:2];
    assign word_idx  = word_addr[AW-1:0];
    assign addr_err  = (req_addr_i[1:0] != 2'b00) || (word_addr >= 30'(DEPTH_WORDS));
    assign accept    = req_valid_i && req_ready_o;
    assign wr_en     = accept && req_write_i && !addr_err;

    // NOTE: storage has no reset; the INIT sweep clears it one word per cycle instead.
    always_ff @(posedge clk_i) begin
        if (clear_en) begin
            mem_q[init_idx_q[AW-1:0]] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (req_strb_i[b]) mem_q[word_idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
            end
        end
    end

    // Reads sample storage at the accepting edge, so a write one cycle earlier is visible
    always_comb begin
        new_rsp.err   = addr_err;
        new_rsp.id    = req_id_i;
        new_rsp.rdata = (!req_write_i && !addr_err) ? mem_q[word_idx] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid_q <= '0;
        end else begin
            pipe_valid_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pipe_valid_q[i] <= pipe_valid_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        pipe_q[0] <= new_rsp;
        for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end

    assign push        = pipe_valid_q[LATENCY-1];
    assign rsp_valid_o = (fifo_cnt_q != '0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign head        = fifo_q[rd_ptr_q];

    // The outstanding limit bounds pipeline plus FIFO, so a push never finds the FIFO full
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= pipe_q[LATENCY-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign rsp_rdata_o = rsp_valid_o ? head.rdata : '0;
    assign rsp_id_o    = rsp_valid_o ? head.id    : '0;
    assign rsp_error_o = rsp_valid_o ? head.err   : 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_q     <= '0;
            err_count_o <= '0;
        end else begin
            unique case ({accept, pop})
                2'b10:   outst_q <= outst_q + CW'(1);
                2'b01:   outst_q <= outst_q - CW'(1);
                default: outst_q <= outst_q;
            endcase
            if (accept && addr_err && (err_count_o != 16'hFFFF))
                err_count_o <= err_count_o + 16'd1;
        end
    end

endmodule
